// File: rtl/game_control_multi.sv
// Bird/wall game controller: one bird FSM, NUM_WALLS scrolling wall channels,
// frame-tick physics, LFSR gap randomisation, collision, score and hi-score.
module game_control_multi #(
  parameter int NUM_WALLS      = 3,
  parameter int X_W            = 9,
  parameter int Y_W            = 7,
  parameter int SCORE_W        = 8,
  parameter int SCREEN_W       = 160,
  parameter int SCREEN_H       = 120,
  parameter int BIRD_X         = 40,
  parameter int BIRD_Y0        = 60,
  parameter int BIRD_SZ        = 8,
  parameter int WALL_W         = 16,
  parameter int WALL_SPACING   = 60,
  parameter int WALL_SPEED     = 2,
  parameter int GAP_H          = 40,
  parameter int GAP_MIN        = 10,
  parameter int GAP_RANGE_LOG2 = 6,
  parameter int GRAVITY        = 1,
  parameter int FLAP_V         = 6,
  parameter int VMAX           = 6
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     go,
  input  logic                     frame_tick,
  output logic [1:0]               state,
  output logic [Y_W-1:0]           bird_y,
  output logic [NUM_WALLS*X_W-1:0] wall_x,
  output logic [NUM_WALLS*Y_W-1:0] wall_gap,
  output logic                     collision,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       hi_score
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} state_t;

  localparam logic [X_W-1:0]        SPEED_X = X_W'(WALL_SPEED);
  localparam logic [X_W-1:0]        WRAP_X  = X_W'(NUM_WALLS*WALL_SPACING - WALL_SPEED);
  localparam logic [X_W-1:0]        BX      = X_W'(BIRD_X);
  localparam logic [X_W-1:0]        BX_END  = X_W'(BIRD_X + BIRD_SZ);
  localparam logic [X_W:0]          BX_W    = (X_W+1)'(BIRD_X);
  localparam logic [X_W:0]          WW      = (X_W+1)'(WALL_W);
  localparam logic [Y_W-1:0]        GROUND  = Y_W'(SCREEN_H - BIRD_SZ);
  localparam logic [Y_W:0]          BSZ_Y   = (Y_W+1)'(BIRD_SZ);
  localparam logic [Y_W:0]          GAPH    = (Y_W+1)'(GAP_H);
  localparam logic [Y_W-1:0]        Y0      = Y_W'(BIRD_Y0);
  localparam logic [Y_W-1:0]        GMIN    = Y_W'(GAP_MIN);
  localparam logic signed [Y_W:0]   FLAP_S  = (Y_W+1)'(-FLAP_V);
  localparam logic signed [Y_W:0]   GRAV_S  = (Y_W+1)'(GRAVITY);
  localparam logic signed [Y_W:0]   VMAX_S  = (Y_W+1)'(VMAX);
  localparam logic [SCORE_W:0]      SMAX    = {1'b0, {SCORE_W{1'b1}}};

  state_t                 st, st_n;
  logic                   go_q, press, hit;
  logic                   flap_pending, flap_pending_n;
  logic signed [Y_W:0]    vel, vel_n, vel_t, vel_g;
  logic signed [Y_W+1:0]  y_sum;
  logic [Y_W-1:0]         y_t, bird_y_n;
  logic [X_W-1:0]         wx [NUM_WALLS];
  logic [X_W-1:0]         wx_n [NUM_WALLS];
  logic [X_W-1:0]         wx_t [NUM_WALLS];
  logic [Y_W-1:0]         wg [NUM_WALLS];
  logic [Y_W-1:0]         wg_n [NUM_WALLS];
  logic [Y_W-1:0]         wg_t [NUM_WALLS];
  logic [SCORE_W:0]       pass_cnt, score_sum;
  logic [SCORE_W-1:0]     score_t, score_n, hi_score_n;
  logic                   collision_n;
  logic [15:0]            lfsr, lfsr_n;

  assign press  = go & ~go_q;
  assign lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign state  = st;

  always_comb begin
    wall_x   = '0;
    wall_gap = '0;
    for (int unsigned i = 0; i < NUM_WALLS; i++) begin
      wall_x[i*X_W +: X_W]   = wx[i];
      wall_gap[i*Y_W +: Y_W] = wg[i];
    end
  end

  // Collision on the registered positions: ground, or horizontal overlap outside the gap.
  always_comb begin
    hit = (bird_y >= GROUND);
    for (int unsigned i = 0; i < NUM_WALLS; i++) begin
      if ((({1'b0, wx[i]} + WW) > BX_W) && (wx[i] < BX_END) &&
          ((bird_y < wg[i]) || (({1'b0, bird_y} + BSZ_Y) > ({1'b0, wg[i]} + GAPH))))
        hit = 1'b1;
    end
  end

  // Candidate per-tick physics; only committed when a tick is applied in PLAY.
  always_comb begin
    vel_g = vel + GRAV_S;
    if (flap_pending | press) vel_t = FLAP_S;
    else                      vel_t = (vel_g > VMAX_S) ? VMAX_S : vel_g;
    y_sum = $signed({2'b00, bird_y}) + $signed({vel_t[Y_W], vel_t});
    if (y_sum[Y_W+1])  y_t = '0;
    else if (y_sum[Y_W]) y_t = '1;
    else               y_t = y_sum[Y_W-1:0];
    pass_cnt = '0;
    for (int unsigned i = 0; i < NUM_WALLS; i++) begin
      wg_t[i] = wg[i];
      if (wx[i] >= SPEED_X) begin
        wx_t[i] = wx[i] - SPEED_X;
        if (wx[i] >= BX && wx_t[i] < BX) pass_cnt = pass_cnt + (SCORE_W+1)'(1);
      end else begin
        wx_t[i] = wx[i] + WRAP_X;
        wg_t[i] = GMIN + Y_W'(lfsr[GAP_RANGE_LOG2-1:0]);
      end
    end
    score_sum = {1'b0, score} + pass_cnt;
    score_t   = (score_sum > SMAX) ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) st <= IDLE;
    else         st <= st_n;
  end

  always_comb begin
    st_n = st;
    case (st)
      IDLE:    if (press) st_n = PLAY;
      PLAY:    if (hit)   st_n = DEAD;
      DEAD:    if (press) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    bird_y_n       = bird_y;
    vel_n          = vel;
    flap_pending_n = flap_pending;
    score_n        = score;
    hi_score_n     = hi_score;
    collision_n    = collision;
    wx_n           = wx;
    wg_n           = wg;
    case (st)
      PLAY: begin
        // A detected collision pre-empts any tick arriving in the same cycle.
        if (hit) begin
          collision_n = 1'b1;
          if (score > hi_score) hi_score_n = score;
        end else if (frame_tick) begin
          vel_n          = vel_t;
          bird_y_n       = y_t;
          wx_n           = wx_t;
          wg_n           = wg_t;
          score_n        = score_t;
          flap_pending_n = 1'b0;
        end else if (press) begin
          flap_pending_n = 1'b1;
        end
      end
      DEAD: begin
        if (press) begin
          bird_y_n       = Y0;
          vel_n          = '0;
          flap_pending_n = 1'b0;
          score_n        = '0;
          collision_n    = 1'b0;
          for (int unsigned i = 0; i < NUM_WALLS; i++) begin
            wx_n[i] = X_W'(SCREEN_W + i*WALL_SPACING);
            wg_n[i] = GMIN;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bird_y       <= Y0;
      vel          <= '0;
      flap_pending <= 1'b0;
      go_q         <= 1'b0;
      score        <= '0;
      hi_score     <= '0;
      collision    <= 1'b0;
      lfsr         <= 16'hACE1;
      for (int unsigned i = 0; i < NUM_WALLS; i++) begin
        wx[i] <= X_W'(SCREEN_W + i*WALL_SPACING);
        wg[i] <= GMIN;
      end
    end else begin
      bird_y       <= bird_y_n;
      vel          <= vel_n;
      flap_pending <= flap_pending_n;
      go_q         <= go;
      score        <= score_n;
      hi_score     <= hi_score_n;
      collision    <= collision_n;
      lfsr         <= lfsr_n;
      wx           <= wx_n;
      wg           <= wg_n;
    end
  end

endmodule

// File: tb/tb_game_control_multi.sv
// Directed bench for game_control_multi: hand-computed trajectories, wall
// scrolling/wrap, scoring, death, restart and asynchronous reset.
module tb_game_control_multi;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        go = 1'b0;
  logic        frame_tick = 1'b0;
  logic [1:0]  state;
  logic [6:0]  bird_y;
  logic [26:0] wall_x;
  logic [20:0] wall_gap;
  logic        collision;
  logic [7:0]  score;
  logic [7:0]  hi_score;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_lfsr;
  logic [6:0]  exp_gap;

  game_control_multi dut (
    .clk(clk), .resetn(resetn), .go(go), .frame_tick(frame_tick),
    .state(state), .bird_y(bird_y), .wall_x(wall_x), .wall_gap(wall_gap),
    .collision(collision), .score(score), .hi_score(hi_score)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11, seeded 16'hACE1, advancing every clock.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    go = 1'b0; frame_tick = 1'b0; resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic press();
    go = 1'b1; @(negedge clk);
    go = 1'b0; @(negedge clk);
  endtask

  task automatic tick(input logic flap);
    go = flap; frame_tick = 1'b1; @(negedge clk);
    go = 1'b0; frame_tick = 1'b0; @(negedge clk);
  endtask

  initial begin
    // Reset and IDLE: ticks move nothing
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_bird_y", bird_y, 60);
    chk("rst_wall_x", wall_x, {9'd280, 9'd220, 9'd160});
    chk("rst_wall_gap", wall_gap, {7'd10, 7'd10, 7'd10});
    chk("rst_score", score, 0);
    chk("rst_hi", hi_score, 0);
    chk("rst_coll", collision, 0);
    repeat (10) tick(1'b0);
    chk("idle_state", state, 0);
    chk("idle_bird_y", bird_y, 60);
    chk("idle_wall_x", wall_x, {9'd280, 9'd220, 9'd160});

    // Free fall, flap between ticks, top clamp, single press on held key
    press();
    chk("play_state", state, 1);
    chk("play_bird_y_pre", bird_y, 60);
    tick(1'b0); chk("fall1_y", bird_y, 61); chk("fall1_x0", wall_x[8:0], 158);
    tick(1'b0); chk("fall2_y", bird_y, 63); chk("fall2_x0", wall_x[8:0], 156);
    tick(1'b0); chk("fall3_y", bird_y, 66); chk("fall3_x0", wall_x[8:0], 154);
    chk("fall3_state", state, 1);
    press();
    chk("pend_y_hold", bird_y, 66);
    tick(1'b0); chk("pend_flap_y", bird_y, 60);
    repeat (8) tick(1'b1);
    chk("flap8_y", bird_y, 12);
    tick(1'b0); tick(1'b0);
    chk("near_top_y", bird_y, 3);
    tick(1'b1);
    chk("clamp_y", bird_y, 0);
    chk("clamp_coll", collision, 0);
    chk("clamp_state", state, 1);
    repeat (12) tick(1'b0);
    chk("recover_y", bird_y, 21);
    chk("recover_x0", wall_x[8:0], 106);
    go = 1'b1; frame_tick = 1'b1; @(negedge clk);
    frame_tick = 1'b0;
    chk("flap_same_tick_y", bird_y, 15);
    for (int c = 1; c < 20; c++) begin
      frame_tick = (c == 4 || c == 9);
      @(negedge clk);
    end
    go = 1'b0; frame_tick = 1'b0; @(negedge clk);
    chk("held_go_y", bird_y, 6);
    chk("held_go_x0", wall_x[8:0], 100);

    // Ground death with a back-to-back tick on the detection cycle
    do_reset();
    press();
    repeat (11) tick(1'b0);
    chk("pre_ground_y", bird_y, 111);
    chk("pre_ground_coll", collision, 0);
    frame_tick = 1'b1; @(negedge clk);
    chk("ground_y", bird_y, 117);
    chk("ground_state_T", state, 1);
    chk("ground_coll_T", collision, 0);
    @(negedge clk);
    frame_tick = 1'b0;
    chk("dead_state", state, 2);
    chk("dead_coll", collision, 1);
    chk("dead_tick_ignored_y", bird_y, 117);
    chk("dead_tick_ignored_x0", wall_x[8:0], 136);
    repeat (5) tick(1'b0);
    chk("dead_frozen_y", bird_y, 117);
    chk("dead_frozen_x", wall_x, {9'd256, 9'd196, 9'd136});
    chk("dead_hi0", hi_score, 0);

    // Flying through the gaps: scoring, wrap with random gap, then death
    do_reset();
    press();
    for (int t = 1; t <= 121; t++) begin
      if (t == 81) exp_gap = 7'd10 + {1'b0, m_lfsr[5:0]};
      tick((t <= 4) || ((t - 4) % 13 == 0));
      if (t == 59) begin chk("x0_42", wall_x[8:0], 42); chk("score_at42", score, 0); end
      if (t == 60) begin chk("x0_40", wall_x[8:0], 40); chk("score_at40", score, 0); end
      if (t == 61) begin chk("x0_38", wall_x[8:0], 38); chk("score_at38", score, 1); end
      if (t == 80) chk("x0_zero", wall_x[8:0], 0);
      if (t == 81) begin
        chk("wrap_x0", wall_x[8:0], 178);
        chk("wrap_gap0", wall_gap[6:0], exp_gap);
        chk("wrap_x1", wall_x[17:9], 58);
      end
      if (t == 91) chk("score_wall1", score, 2);
    end
    chk("score_wall2", score, 3);
    chk("fly_state", state, 1);
    chk("fly_bird_y", bird_y, 36);
    begin
      int budget = 40;
      while (state != 2'd2 && budget > 0) begin
        tick(1'b0);
        budget--;
      end
    end
    chk("fly_dead_state", state, 2);
    chk("fly_dead_coll", collision, 1);
    chk("fly_dead_score", score, 3);
    chk("fly_dead_hi", hi_score, 3);

    // Restart keeps hi_score; asynchronous reset clears it without a clock edge
    press();
    chk("restart_state", state, 0);
    chk("restart_score", score, 0);
    chk("restart_bird_y", bird_y, 60);
    chk("restart_wall_x", wall_x, {9'd280, 9'd220, 9'd160});
    chk("restart_gap", wall_gap, {7'd10, 7'd10, 7'd10});
    chk("restart_coll", collision, 0);
    chk("restart_hi", hi_score, 3);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_hi", hi_score, 0);
    chk("async_rst_state", state, 0);
    resetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
